// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results and in-order load
// responses onto one register-file write port. ALU results always win;
// load responses are paired with destination tags held in a small FIFO,
// which also serves as a scoreboard of registers with a load in flight.
// Optional feature: define WB_BYPASS_EN to forward the registered write
// port back to the a/b read queries.
module writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_rd,
  output logic        issue_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [4:0]  Daddress,
  output logic [31:0] Ddata,
  output logic        write,
  input  logic [4:0]  a_addr,
  input  logic [4:0]  b_addr,
  output logic        a_busy,
  output logic        b_busy,
  output logic        a_fwd,
  output logic        b_fwd,
  output logic [31:0] a_fwd_data,
  output logic [31:0] b_fwd_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       tag_rd [DEPTH];
  logic [DEPTH-1:0] tag_vld;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             accept;
  logic [4:0]       head_rd;
  logic             a_hit;
  logic             b_hit;

  // A pop in the same cycle does not free a slot for a push: fullness is
  // judged on the pre-edge count only.
  assign issue_ready = rst && (count < CW'(DEPTH));
  assign ld_ready    = rst && !alu_valid && (count != '0);
  assign push        = ld_issue && issue_ready;
  assign accept      = ld_valid && ld_ready;
  assign head_rd     = tag_rd[rptr];

  // Tag FIFO control: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      tag_vld <= '0;
    end else begin
      if (push) begin
        tag_vld[wptr] <= 1'b1;
        wptr          <= wptr + PW'(1);
      end
      if (accept) begin
        tag_vld[rptr] <= 1'b0;
        rptr          <= rptr + PW'(1);
      end
      case ({push, accept})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag storage; contents are qualified by tag_vld so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) tag_rd[wptr] <= ld_rd;
  end

  // Registered write port; rd 0 results are consumed but never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write    <= 1'b0;
      Daddress <= '0;
      Ddata    <= '0;
    end else if (alu_valid) begin
      write    <= (alu_rd != 5'd0);
      Daddress <= alu_rd;
      Ddata    <= alu_data;
    end else if (accept) begin
      write    <= (head_rd != 5'd0);
      Daddress <= head_rd;
      Ddata    <= ld_data;
    end else begin
      write    <= 1'b0;
    end
  end

  // Scoreboard lookup against the pre-edge FIFO contents.
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tag_vld[i] && (tag_rd[i] == a_addr)) a_hit = 1'b1;
      if (tag_vld[i] && (tag_rd[i] == b_addr)) b_hit = 1'b1;
    end
  end

  assign a_busy = rst && (a_addr != 5'd0) && a_hit;
  assign b_busy = rst && (b_addr != 5'd0) && b_hit;

`ifdef WB_BYPASS_EN
  assign a_fwd      = write && (Daddress == a_addr) && (a_addr != 5'd0);
  assign b_fwd      = write && (Daddress == b_addr) && (b_addr != 5'd0);
  assign a_fwd_data = Ddata;
  assign b_fwd_data = Ddata;
`else
  assign a_fwd      = 1'b0;
  assign b_fwd      = 1'b0;
  assign a_fwd_data = '0;
  assign b_fwd_data = '0;
`endif

endmodule
